// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: operands are captured on start and processed
// SLICE bits per clock, LSB slice first; result and zero flag update on completion.
module logic_unit_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 1) || (SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
      $error("logic_unit_serial: illegal WIDTH/SLICE combination");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] o,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (o)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      3'b111:  r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d;

  // Next-state: capture in IDLE, one slice per cycle in RUN, publish on the last slice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Constant slice positions keep the part-selects static.
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            acc_d[k*SLICE +: SLICE] = slice_op(op_q, a_q[k*SLICE +: SLICE], b_q[k*SLICE +: SLICE]);
          end else begin
            acc_d[k*SLICE +: SLICE] = acc_q[k*SLICE +: SLICE];
          end
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
          s_d     = acc_d;
          zero_d  = (acc_d == {WIDTH{1'b0}});
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 3'b000;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign zero = zero_q;

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Parametrised, multi-cycle bitwise logic unit that generalises the 4-bit single-operation OR datapath to any operand width and eight logic operations. Operands and opcode are captured on a start handshake and processed in SLICE-bit slices, LSB slice first, one slice per clock. The result and a zero flag are registered and held until the next completion. The block sits beside the arithmetic units in the calculator datapath, and the control FSM drives it through start/busy/done.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 1.
- SLICE, 4: bits processed per clock; 1 ≤ SLICE ≤ WIDTH; WIDTH % SLICE == 0 (elaboration error otherwise).
- N (localparam), WIDTH/SLICE: number of processing cycles.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation select; captured with start.
- A  in  WIDTH  operand A; captured with start.
- B  in  WIDTH  operand B; captured with start.
- busy  out  1  high while a request is being processed.
- done  out  1  one-cycle pulse when S/zero update.
- S  out  WIDTH  registered result; holds between completions.
- zero  out  1  registered; high when the last result was all zeros.

## Operation
- Opcodes:
  - 000 AND; 001 OR; 010 XOR; 011 NAND; 100 NOR; 101 XNOR.
  - 110 NOT A (B ignored).
  - 111 PASS A (B ignored).
- States:
  - IDLE:
    - start=1 → capture A, B, op into internal registers; slice counter := 0; go to RUN.
    - start=0 → stay in IDLE.
  - RUN:
    - Each cycle, compute f(op) on the captured slice [k*SLICE +: SLICE] and write it into an internal accumulator at the same position; k increments.
    - When k == N-1:
      - load S with the full accumulator (including this last slice);
      - zero := (that value == 0);
      - pulse done;
      - return to IDLE.
- Captured operands are the only datapath source. Changes on A/B/op during RUN have no effect.
- start during RUN is ignored: not queued, no error.
- S and zero change only on a completion edge or reset. There are no partial updates visible on S.
- SLICE == WIDTH (N=1) is legal: RUN lasts one cycle.
- Reset (rst_n=0 at a rising edge), in any state including mid-RUN:
  - state := IDLE; counter := 0; accumulator := 0;
  - busy = 0, done = 0, S = 0, zero = 0.
  - An aborted operation produces no done and does not modify S.

## Timing
- Request accepted at edge E0 (IDLE, start=1).
- busy = 1 from E0 until edge EN; busy is a registered output, equal to (state == RUN).
- Completion at edge EN:
  - S and zero valid from EN onward.
  - done = 1 for exactly the cycle between EN and EN+1.
  - busy = 0 in that same cycle.
- Latency from start sample to done: N cycles.
- Throughput: a new start in the done cycle is accepted at EN+1, so one request per N+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset has priority over start at the same edge.

## Test plan
- Reset and idle, WIDTH=8, SLICE=4:
  - hold rst_n=0 for 2 cycles → S=0x00, zero=0, busy=0, done=0;
  - release with start=0 for 5 cycles → outputs unchanged.
- OR, WIDTH=8, SLICE=4: start with op=001, A=0xA5, B=0x0F → busy high 2 cycles, then done pulse 1 cycle, S=0xAF, zero=0.
- All opcodes, WIDTH=8, SLICE=4, A=0xC3, B=0x5A:
  - AND 0x42, OR 0xDB, XOR 0x99, NAND 0xBD;
  - NOR 0x24, XNOR 0x66, NOT 0x3C, PASS 0xC3.
- Zero flag and input isolation:
  - XOR with A=B=0x77 → S=0x00, zero=1.
  - Change A to 0xFF during busy → result still 0x00.
  - start=1 during busy → no extra done.
- Reset mid-operation, WIDTH=16, SLICE=4:
  - start AND, A=0xFFFF, B=0x1234;
  - assert rst_n=0 at the 2nd RUN edge → S=0x0000, busy=0, no done;
  - a following request completes normally → S=0x1234 after 4 cycles.
- Back-to-back and bounds:
  - start held high continuously → done every N+1 cycles;
  - WIDTH=8, SLICE=8 → latency 1;
  - WIDTH=8, SLICE=1 → latency 8, correct S.
